// File: rtl/rst_seq_ctl.sv
// rst_seq_ctl: lock-debounced staged reset sequencer with divided clock-enable and lock-loss recording
module rst_seq_ctl #(
  parameter int N_RST       = 3,
  parameter int LOCK_CYCLES = 1024,
  parameter int STAGE_GAP   = 16,
  parameter int DIV_RATIO   = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             pll_locked_i,
  input  logic             sw_rst_i,
  input  logic             lock_clr_i,
  output logic [N_RST-1:0] rst_n_o,
  output logic             ready_o,
  output logic             clk_en_o,
  output logic             lock_lost_o,
  output logic [7:0]       loss_cnt_o
);
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam int GW = $clog2(STAGE_GAP + 1);
  localparam int DW = $clog2(DIV_RATIO + 1);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_CYCLES);
  localparam logic [GW-1:0] GAP_MAX  = GW'(STAGE_GAP - 1);
  localparam logic [DW-1:0] DIV_MAX  = DW'(DIV_RATIO - 1);

  typedef enum logic [2:0] {IDLE, STABLE, RELEASE, HOLD, RUN} state_t;

  state_t           state_q, state_d;
  logic             sync_q, lock_s;
  logic [LW-1:0]    lcnt_q, lcnt_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic [N_RST-1:0] rst_d;
  logic             ready_d, clk_en_d, lost_d, loss, sw;
  logic [7:0]       loss_cnt_d;

  // next state, counters and registered-output values; lock loss beats sw_rst_i
  always_comb begin
    loss       = !lock_s && (state_q inside {RELEASE, HOLD, RUN});
    sw         = sw_rst_i && (state_q inside {RELEASE, RUN});
    state_d    = state_q;
    lcnt_d     = lcnt_q;
    gcnt_d     = gcnt_q;
    dcnt_d     = dcnt_q;
    rst_d      = rst_n_o;
    ready_d    = ready_o;
    clk_en_d   = 1'b0;
    lost_d     = loss || (lock_lost_o && !lock_clr_i);
    loss_cnt_d = (loss && loss_cnt_o != 8'hff) ? loss_cnt_o + 8'd1 : loss_cnt_o;
    if (loss) begin
      state_d = IDLE;
      rst_d   = '0;
      ready_d = 1'b0;
    end else if (sw) begin
      state_d = HOLD;
      gcnt_d  = '0;
      rst_d   = '0;
      ready_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = lock_s ? STABLE : IDLE;
          lcnt_d  = '0;
        end
        STABLE: begin
          if (!lock_s) state_d = IDLE;
          else if (lcnt_q == LOCK_MAX) begin
            state_d = RELEASE;
            rst_d   = N_RST'(1);
            gcnt_d  = '0;
          end else lcnt_d = lcnt_q + LW'(1);
        end
        RELEASE: begin
          gcnt_d = (gcnt_q == GAP_MAX) ? '0 : gcnt_q + GW'(1);
          if (gcnt_q == GAP_MAX && &rst_n_o) begin
            state_d = RUN;
            ready_d = 1'b1;
            dcnt_d  = '0;
          end else if (gcnt_q == GAP_MAX) rst_d = (rst_n_o << 1) | N_RST'(1);
        end
        HOLD: begin
          if (sw_rst_i) gcnt_d = '0;
          else if (gcnt_q == GAP_MAX) begin
            state_d = RELEASE;
            rst_d   = N_RST'(1);
            gcnt_d  = '0;
          end else gcnt_d = gcnt_q + GW'(1);
        end
        RUN: begin
          clk_en_d = dcnt_q == DIV_MAX;
          dcnt_d   = (dcnt_q == DIV_MAX) ? '0 : dcnt_q + DW'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // lock synchroniser, state, counters and all outputs
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync_q      <= 1'b0;
      lock_s      <= 1'b0;
      state_q     <= IDLE;
      lcnt_q      <= '0;
      gcnt_q      <= '0;
      dcnt_q      <= '0;
      rst_n_o     <= '0;
      ready_o     <= 1'b0;
      clk_en_o    <= 1'b0;
      lock_lost_o <= 1'b0;
      loss_cnt_o  <= '0;
    end else begin
      sync_q      <= pll_locked_i;
      lock_s      <= sync_q;
      state_q     <= state_d;
      lcnt_q      <= lcnt_d;
      gcnt_q      <= gcnt_d;
      dcnt_q      <= dcnt_d;
      rst_n_o     <= rst_d;
      ready_o     <= ready_d;
      clk_en_o    <= clk_en_d;
      lock_lost_o <= lost_d;
      loss_cnt_o  <= loss_cnt_d;
    end
  end
endmodule

// File: tb/tb_rst_seq_ctl.sv
// tb_rst_seq_ctl: directed timeline checks plus random stimulus against a timestamp-based reference model
module tb_rst_seq_ctl;
  localparam int N = 3, LC = 8, SG = 4, DR = 3;
  localparam int M_IDLE = 0, M_STABLE = 1, M_HOLD = 2, M_SEQ = 3;

  logic clk_i = 0, rst_n_i = 0, pll_locked_i = 0, sw_rst_i = 0, lock_clr_i = 0;
  logic [N-1:0] rst_n_o;
  logic ready_o, clk_en_o, lock_lost_o;
  logic [7:0] loss_cnt_o;
  int checks = 0, failures = 0;
  bit chk_on = 0;

  int n = 0, mode = M_IDLE, anchor = 0, m_cnt = 0;
  bit s1 = 0, s2 = 0, m_lost = 0;

  rst_seq_ctl #(.N_RST(N), .LOCK_CYCLES(LC), .STAGE_GAP(SG), .DIV_RATIO(DR)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .pll_locked_i(pll_locked_i), .sw_rst_i(sw_rst_i),
    .lock_clr_i(lock_clr_i), .rst_n_o(rst_n_o), .ready_o(ready_o), .clk_en_o(clk_en_o),
    .lock_lost_o(lock_lost_o), .loss_cnt_o(loss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(int k);
    repeat (k) @(negedge clk_i);
  endtask

  // reference model: a sequence is described only by the edge it started on
  always @(posedge clk_i) begin
    bit ls, loss, sw;
    n++;
    if (!rst_n_i) begin
      mode = M_IDLE; s1 = 0; s2 = 0; m_lost = 0; m_cnt = 0;
    end else begin
      ls   = s2;
      loss = !ls && (mode == M_SEQ || mode == M_HOLD);
      sw   = sw_rst_i && mode == M_SEQ;
      m_lost = loss || (m_lost && !lock_clr_i);
      if (loss && m_cnt < 255) m_cnt++;
      if (loss) mode = M_IDLE;
      else if (sw) begin mode = M_HOLD; anchor = n; end
      else if (mode == M_IDLE && ls) begin mode = M_STABLE; anchor = n; end
      else if (mode == M_STABLE) begin
        if (!ls) mode = M_IDLE;
        else if (n == anchor + LC + 1) begin mode = M_SEQ; anchor = n; end
      end else if (mode == M_HOLD) begin
        if (sw_rst_i) anchor = n;
        else if (n == anchor + SG) begin mode = M_SEQ; anchor = n; end
      end
      s2 = s1;
      s1 = pll_locked_i;
    end
  end

  // compare every output against the model away from the active edge
  always @(negedge clk_i) begin
    int t, u;
    logic [N-1:0] e_rst;
    bit e_rdy, e_en;
    if (chk_on) begin
      t = n - anchor;
      for (int k = 0; k < N; k++) e_rst[k] = mode == M_SEQ && t >= k * SG;
      e_rdy = mode == M_SEQ && t >= N * SG;
      u = t - N * SG;
      e_en = e_rdy && u > 0 && u % DR == 0;
      chk("m_rst_n", rst_n_o, e_rst);
      chk("m_ready", ready_o, e_rdy);
      chk("m_clk_en", clk_en_o, e_en);
      chk("m_lost", lock_lost_o, m_lost);
      chk("m_cnt", loss_cnt_o, m_cnt);
    end
  end

  initial begin
    step(3);
    chk_on = 1;
    chk("rst_state", {rst_n_o, ready_o, clk_en_o, lock_lost_o, loss_cnt_o}, 0);
    rst_n_i = 1;
    step(2);
    pll_locked_i = 1;
    step(8);
    pll_locked_i = 0;
    step(3);
    chk("glitch_cnt", loss_cnt_o, 0);
    pll_locked_i = 1;
    step(11); chk("rel0_pre", rst_n_o, 3'b000);
    step(1);  chk("rel0", rst_n_o, 3'b001);
    step(4);  chk("rel1", rst_n_o, 3'b011);
    step(4);  chk("rel2", rst_n_o, 3'b111);
    chk("rdy_pre", ready_o, 0);
    step(4);  chk("rdy", ready_o, 1);
    step(3);  chk("en26", clk_en_o, 1);
    step(1);  chk("en27", clk_en_o, 0);
    step(2);  chk("en29", clk_en_o, 1);
    pll_locked_i = 0;
    step(2);  chk("run_still", ready_o, 1);
    step(1);
    chk("loss_rst", rst_n_o, 3'b000);
    chk("loss_rdy", ready_o, 0);
    chk("loss_flag", lock_lost_o, 1);
    chk("loss_cnt1", loss_cnt_o, 1);
    pll_locked_i = 1;
    step(40); chk("relock_rdy", ready_o, 1);
    sw_rst_i = 1; step(1); sw_rst_i = 0;
    chk("hold_rst", rst_n_o, 3'b000);
    step(3);  chk("hold_end", rst_n_o, 3'b000);
    step(1);  chk("hold_rel0", rst_n_o, 3'b001);
    step(12); chk("hold_rdy", ready_o, 1);
    chk("hold_cnt", loss_cnt_o, 1);
    sw_rst_i = 1; step(1); sw_rst_i = 0;
    step(8);  chk("mid_rel", rst_n_o, 3'b011);
    rst_n_i = 0; step(1);
    chk("mid_rst", {rst_n_o, ready_o, clk_en_o, lock_lost_o, loss_cnt_o}, 0);
    rst_n_i = 1;
    step(40); chk("rerun_rdy", ready_o, 1);
    for (int i = 0; i < 300; i++) begin
      step(20);
      pll_locked_i = 0; step(1);
      pll_locked_i = 1; step(1);
      sw_rst_i = 1; lock_clr_i = 1; step(1);
      sw_rst_i = 0; lock_clr_i = 0;
      if (i < 3) chk("set_over_clr", lock_lost_o, 1);
    end
    chk("sat_cnt", loss_cnt_o, 255);
    lock_clr_i = 1; step(1); lock_clr_i = 0;
    chk("clr_flag", lock_lost_o, 0);
    chk("clr_keeps_cnt", loss_cnt_o, 255);
    for (int i = 0; i < 3000; i++) begin
      pll_locked_i = pll_locked_i ? ($urandom_range(0, 99) != 0) : ($urandom_range(0, 99) < 30);
      sw_rst_i = $urandom_range(0, 99) < 2;
      lock_clr_i = $urandom_range(0, 99) < 3;
      rst_n_i = $urandom_range(0, 999) != 0;
      step(1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
